// File: rtl/rv32_bus_arbiter.sv
// rtl/rv32_bus_arbiter.sv - merges rv32 fetch and data buses onto one shared memory bus
// Optional RV32_ARBITER_ROUND_ROBIN_EN: alternate priority when both ports request in IDLE.
module rv32_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,
  output logic [31:0] mem_address_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [3:0]  mem_write_mask_out,
  output logic [31:0] mem_write_value_out,
  input  logic [31:0] mem_read_value_in,
  input  logic        mem_ready_in,
  output logic        timeout_out
);

  typedef enum logic [1:0] {IDLE, OWN_INSTR, OWN_DATA} state_t;

  localparam logic [15:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        instr_req;
  logic        data_req;
  logic        gnt_instr;
  logic        gnt_data;
  logic        timeout_hit;

`ifdef RV32_ARBITER_ROUND_ROBIN_EN
  logic        last_grant;  // 0 = instr, 1 = data
`endif

  assign instr_req = instr_read_in;
  assign data_req  = data_read_in | data_write_in;

  // Once owned, only the owner can be granted; dropping its request is a flush.
  always_comb begin
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    if (reset_) begin
      case (state)
        IDLE: begin
`ifdef RV32_ARBITER_ROUND_ROBIN_EN
          if (data_req && instr_req) begin
            gnt_data  = ~last_grant;
            gnt_instr = last_grant;
          end else begin
            gnt_data  = data_req;
            gnt_instr = instr_req;
          end
`else
          gnt_data  = data_req;
          gnt_instr = instr_req & ~data_req;
`endif
        end
        OWN_INSTR: gnt_instr = instr_req;
        OWN_DATA:  gnt_data  = data_req;
        default: ;
      endcase
    end
  end

  assign mem_address_out     = gnt_instr ? instr_address_in : (gnt_data ? data_address_in : 32'd0);
  assign mem_read_out        = gnt_instr | (gnt_data & data_read_in);
  assign mem_write_out       = gnt_data & data_write_in;
  assign mem_write_mask_out  = gnt_data ? data_write_mask_in : 4'd0;
  assign mem_write_value_out = gnt_data ? data_write_value_in : 32'd0;

  assign instr_ready_out      = mem_ready_in & gnt_instr;
  assign data_ready_out       = mem_ready_in & gnt_data;
  assign instr_read_value_out = reset_ ? mem_read_value_in : 32'd0;
  assign data_read_value_out  = reset_ ? mem_read_value_in : 32'd0;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TMO_LAST) && !mem_ready_in;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state       <= IDLE;
      wait_cnt    <= 16'd0;
      timeout_out <= 1'b0;
`ifdef RV32_ARBITER_ROUND_ROBIN_EN
      last_grant  <= 1'b0;
`endif
    end else begin
      timeout_out <= 1'b0;
`ifdef RV32_ARBITER_ROUND_ROBIN_EN
      if (mem_ready_in && (gnt_instr || gnt_data)) last_grant <= gnt_data;
`endif
      case (state)
        IDLE: begin
          wait_cnt <= 16'd0;
          if (!mem_ready_in) begin
            if (gnt_data)       state <= OWN_DATA;
            else if (gnt_instr) state <= OWN_INSTR;
          end
        end
        OWN_INSTR, OWN_DATA: begin
          if (!(gnt_instr || gnt_data) || mem_ready_in) begin
            state    <= IDLE;
            wait_cnt <= 16'd0;
          end else if (timeout_hit) begin
            state       <= IDLE;
            wait_cnt    <= 16'd0;
            timeout_out <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// tb/tb_rv32_bus_arbiter.sv - randomized bench for rv32_bus_arbiter against a transaction-level model
module tb_rv32_bus_arbiter;

  localparam int TMO = 4;

  logic        clk;
  logic        reset_;
  logic [31:0] instr_address_in;
  logic        instr_read_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic [31:0] data_address_in;
  logic        data_read_in;
  logic        data_write_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic [31:0] mem_address_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [3:0]  mem_write_mask_out;
  logic [31:0] mem_write_value_out;
  logic [31:0] mem_read_value_in;
  logic        mem_ready_in;
  logic        timeout_out;

  rv32_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_(reset_),
    .instr_address_in(instr_address_in), .instr_read_in(instr_read_in),
    .instr_read_value_out(instr_read_value_out), .instr_ready_out(instr_ready_out),
    .data_address_in(data_address_in), .data_read_in(data_read_in),
    .data_write_in(data_write_in), .data_write_mask_in(data_write_mask_in),
    .data_write_value_in(data_write_value_in), .data_read_value_out(data_read_value_out),
    .data_ready_out(data_ready_out), .mem_address_out(mem_address_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .mem_write_mask_out(mem_write_mask_out), .mem_write_value_out(mem_write_value_out),
    .mem_read_value_in(mem_read_value_in), .mem_ready_in(mem_ready_in),
    .timeout_out(timeout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: who holds the bus (0 none, 1 instr, 2 data), how long it has waited,
  // the pending timeout pulse and the most recent completed grant.
  int m_owner = 0;
  int m_waited = 0;
  bit m_tmo = 0;
  int m_last = 1;
  bit last_ir = 0;
  bit last_dr = 0;
  int n_tmo_seen = 0;
  int n_iready_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    int g;
    bit ireq, dreq, rdy;
    int nx_owner, nx_waited;
    bit nx_tmo;
    #1;
    ireq = instr_read_in;
    dreq = data_read_in | data_write_in;
    rdy  = mem_ready_in;
    g = 0;
    if (reset_) begin
      if (m_owner == 0) begin
        if (ireq && dreq) begin
`ifdef RV32_ARBITER_ROUND_ROBIN_EN
          g = (m_last == 2) ? 1 : 2;
`else
          g = 2;
`endif
        end else if (dreq) g = 2;
        else if (ireq) g = 1;
      end else if (m_owner == 1 && ireq) g = 1;
      else if (m_owner == 2 && dreq) g = 2;
    end

    check("mem_address", mem_address_out,
          (g == 1) ? instr_address_in : (g == 2) ? data_address_in : 32'd0);
    check("mem_read", 32'(mem_read_out), (g == 1) ? 32'd1 : (g == 2) ? 32'(data_read_in) : 32'd0);
    check("mem_write", 32'(mem_write_out), (g == 2) ? 32'(data_write_in) : 32'd0);
    check("mem_mask", 32'(mem_write_mask_out), (g == 2) ? 32'(data_write_mask_in) : 32'd0);
    check("mem_wvalue", mem_write_value_out, (g == 2) ? data_write_value_in : 32'd0);
    check("instr_ready", 32'(instr_ready_out), 32'(g == 1 && rdy));
    check("data_ready", 32'(data_ready_out), 32'(g == 2 && rdy));
    check("timeout", 32'(timeout_out), 32'(m_tmo));
    if (!reset_) begin
      check("instr_rvalue_rst", instr_read_value_out, 32'd0);
      check("data_rvalue_rst", data_read_value_out, 32'd0);
    end
    if (g == 1 && rdy) check("instr_rvalue", instr_read_value_out, mem_read_value_in);
    if (g == 2 && rdy) check("data_rvalue", data_read_value_out, mem_read_value_in);

    nx_owner = m_owner;
    nx_waited = 0;
    nx_tmo = 0;
    if (!reset_) begin
      nx_owner = 0;
    end else if (m_owner == 0) begin
      nx_owner = (g != 0 && !rdy) ? g : 0;
    end else if (g == 0 || rdy) begin
      nx_owner = 0;
    end else if (TMO != 0 && m_waited + 1 >= TMO) begin
      nx_owner = 0;
      nx_tmo = 1;
    end else begin
      nx_waited = m_waited + 1;
    end
    last_ir = (g == 1 && rdy);
    last_dr = (g == 2 && rdy);
    if (timeout_out) n_tmo_seen++;
    if (instr_ready_out) n_iready_seen++;

    @(posedge clk);
    m_owner = nx_owner;
    m_waited = nx_waited;
    m_tmo = nx_tmo;
    if (!reset_) m_last = 1;
    else if (g != 0 && rdy) m_last = g;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    instr_read_in = 0; instr_address_in = 0;
    data_read_in = 0; data_write_in = 0; data_address_in = 0;
    data_write_mask_in = 0; data_write_value_in = 0;
    mem_ready_in = 0; mem_read_value_in = 0;
  endtask

  initial begin
    reset_ = 0;
    idle_inputs();
    @(negedge clk);
    instr_read_in = 1; data_write_in = 1; mem_ready_in = 1;
    repeat (3) step();
    reset_ = 1;
    idle_inputs();
    step();

    // Zero-latency fetch on idle bus
    instr_read_in = 1; instr_address_in = 32'h100;
    mem_ready_in = 1; mem_read_value_in = 32'hDEADBEEF;
    step();
    instr_read_in = 0; mem_ready_in = 0;
    step();

    // Both request, two wait cycles per access
    instr_read_in = 1; instr_address_in = 32'h200;
    data_write_in = 1; data_address_in = 32'h80;
    data_write_mask_in = 4'hF; data_write_value_in = 32'h12345678;
    for (int c = 0; c < 6; c++) begin
      mem_ready_in = (c == 2 || c == 5);
      mem_read_value_in = 32'hA000_0000 + 32'(c);
      if (c == 3) begin
        data_write_in = 0; data_write_mask_in = 0; data_write_value_in = 0;
      end
      step();
    end
    idle_inputs();
    step();

    // Load abandoned while owned
    data_read_in = 1; data_address_in = 32'h44;
    step();
    data_read_in = 0;
    repeat (2) step();

    // Timeout on a fetch that never completes, then re-arbitration
    n_tmo_seen = 0;
    n_iready_seen = 0;
    instr_read_in = 1; instr_address_in = 32'h300;
    repeat (8) step();
    check("tmo_pulses", 32'(n_tmo_seen), 32'd1);
    check("tmo_no_ready", 32'(n_iready_seen), 32'd0);
    idle_inputs();
    step();

    // Reset while data owns the bus
    data_read_in = 1; data_address_in = 32'h90;
    repeat (2) step();
    reset_ = 0;
    step();
    reset_ = 1;
    idle_inputs();
    step();

    // Back-to-back fetches, memory always ready
    n_iready_seen = 0;
    mem_ready_in = 1;
    instr_read_in = 1;
    for (int i = 0; i < 3; i++) begin
      instr_address_in = 32'(i * 4);
      mem_read_value_in = 32'h5000 + 32'(i);
      step();
    end
    check("b2b_ready_count", 32'(n_iready_seen), 32'd3);
    idle_inputs();
    step();

    // Randomized traffic with flushes, stalls, timeouts and resets
    for (int c = 0; c < 3000; c++) begin
      reset_ = ($urandom_range(0, 199) != 0);
      if (!(instr_read_in && !last_ir)) begin
        instr_read_in = ($urandom_range(0, 1) == 1);
        instr_address_in = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom_range(0, 19) == 0) begin
        instr_read_in = 0;
      end
      if (!((data_read_in || data_write_in) && !last_dr)) begin
        case ($urandom_range(0, 2))
          0: begin data_read_in = 0; data_write_in = 0; end
          1: begin data_read_in = 1; data_write_in = 0; end
          default: begin data_read_in = 0; data_write_in = 1; end
        endcase
        data_address_in = $urandom;
        data_write_mask_in = 4'($urandom);
        data_write_value_in = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        data_read_in = 0; data_write_in = 0;
      end
      mem_ready_in = ($urandom_range(0, 2) == 0);
      mem_read_value_in = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
